// File: rtl/alu_core_if.sv
// Operand/command bus and registered result/flag bus of alu_core.
// The master drives operands and commands; the slave returns the result and flags.
interface alu_core_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 ce;
    logic                 mode;
    logic                 cin;
    logic [1:0]           inp_valid;
    logic [CMD_WIDTH-1:0] cmd;
    logic [WIDTH:0]       res;
    logic                 oflow;
    logic                 cout;
    logic                 g;
    logic                 l;
    logic                 e;
    logic                 err;

    modport master (
        output opa, opb, ce, mode, cin, inp_valid, cmd,
        input  res, oflow, cout, g, l, e, err
    );

    modport slave (
        input  opa, opb, ce, mode, cin, inp_valid, cmd,
        output res, oflow, cout, g, l, e, err
    );
endinterface

// File: rtl/alu_core.sv
// Registered ALU with arithmetic and logical opcodes, operand-collection wait state,
// a two-cycle multiply path and a 16-edge operand timeout.
module alu_core #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_core_if.slave  bus
);
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0]   ONE     = (WIDTH+1)'(1);
    localparam logic [WIDTH+6:0] ERR_OUT = (WIDTH+7)'(1);

    typedef enum logic [1:0] {IDLE, WAIT, MUL} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_opa, r_opb;
    logic [CMD_WIDTH-1:0] r_cmd;
    logic                 r_mode, r_cin, r_have_a;
    logic [3:0]           r_cnt;
    logic [WIDTH+6:0]     r_out;

    logic [CMD_WIDTH-1:0] w_cmd;
    logic                 w_mode, w_cin;
    logic [WIDTH-1:0]     w_a, w_b;
    logic [3:0]           w_op;
    logic                 w_ill, w_mul;
    logic [1:0]           w_need;
    logic [WIDTH:0]       w_ax, w_bx, w_cx, w_res;
    logic [2*WIDTH-1:0]   w_dbl;
    logic [SHW-1:0]       w_amt;
    logic                 w_oflow, w_cout, w_g, w_l, w_e, w_err;
    logic [WIDTH+6:0]     w_out;

    // Operand source: live inputs in IDLE, latched copy plus the newly arriving operand in WAIT.
    always_comb begin
        w_cmd  = bus.cmd;
        w_mode = bus.mode;
        w_cin  = bus.cin;
        w_a    = bus.opa;
        w_b    = bus.opb;
        if (r_state != IDLE) begin
            w_cmd  = r_cmd;
            w_mode = r_mode;
            w_cin  = r_cin;
            w_a    = r_opa;
            w_b    = r_opb;
            if (r_state == WAIT) begin
                if (r_have_a) w_b = bus.opb;
                else          w_a = bus.opa;
            end
        end
    end

    always_comb begin
        w_op   = w_cmd[3:0];
        w_ill  = (w_cmd >> 4) != '0;
        w_mul  = 1'b0;
        w_need = 2'b11;
        if (w_mode) begin
            case (w_op)
                4'd4, 4'd5:                         w_need = 2'b01;
                4'd6, 4'd7:                         w_need = 2'b10;
                4'd9, 4'd10:                        w_mul  = 1'b1;
                4'd11, 4'd12, 4'd13, 4'd14, 4'd15:  w_ill  = 1'b1;
                default: ;
            endcase
        end else begin
            case (w_op)
                4'd6, 4'd8, 4'd9:    w_need = 2'b01;
                4'd7, 4'd10, 4'd11:  w_need = 2'b10;
                4'd14, 4'd15:        w_ill  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ax    = {1'b0, w_a};
        w_bx    = {1'b0, w_b};
        w_cx    = {{WIDTH{1'b0}}, w_cin};
        w_dbl   = {w_a, w_a};
        w_amt   = w_b[SHW-1:0];
        w_res   = '0;
        w_oflow = 1'b0;
        w_cout  = 1'b0;
        w_g     = 1'b0;
        w_l     = 1'b0;
        w_e     = 1'b0;
        w_err   = 1'b0;
        if (w_ill) begin
            w_err = 1'b1;
        end else if (w_mode) begin
            case (w_op)
                4'd0:  begin w_res = w_ax + w_bx;        w_cout  = w_res[WIDTH]; end
                4'd1:  begin w_res = w_ax - w_bx;        w_oflow = w_ax < w_bx; end
                4'd2:  begin w_res = w_ax + w_bx + w_cx; w_cout  = w_res[WIDTH]; end
                4'd3:  begin w_res = w_ax - w_bx - w_cx; w_oflow = w_ax < (w_bx + w_cx); end
                4'd4:  begin w_res = w_ax + ONE;         w_oflow = &w_a; end
                4'd5:  begin w_res = w_ax - ONE;         w_oflow = ~|w_a; end
                4'd6:  begin w_res = w_bx + ONE;         w_oflow = &w_b; end
                4'd7:  begin w_res = w_bx - ONE;         w_oflow = ~|w_b; end
                4'd8:  begin w_g = w_a > w_b; w_l = w_a < w_b; w_e = w_a == w_b; end
                // Low WIDTH+1 product bits depend only on the low WIDTH+1 factor bits.
                4'd9:  w_res = (w_ax + ONE) * (w_bx + ONE);
                4'd10: w_res = (w_ax << 1) * w_bx;
                default: ;
            endcase
        end else begin
            case (w_op)
                4'd0:  w_res = {1'b0, w_a & w_b};
                4'd1:  w_res = {1'b0, ~(w_a & w_b)};
                4'd2:  w_res = {1'b0, w_a | w_b};
                4'd3:  w_res = {1'b0, ~(w_a | w_b)};
                4'd4:  w_res = {1'b0, w_a ^ w_b};
                4'd5:  w_res = {1'b0, ~(w_a ^ w_b)};
                4'd6:  w_res = {1'b0, ~w_a};
                4'd7:  w_res = {1'b0, ~w_b};
                4'd8:  w_res = {1'b0, w_a >> 1};
                4'd9:  w_res = {1'b0, w_a << 1};
                4'd10: w_res = {1'b0, w_b >> 1};
                4'd11: w_res = {1'b0, w_b << 1};
                4'd12: begin
                    w_res = {1'b0, WIDTH'((w_dbl << w_amt) >> WIDTH)};
                    w_err = (w_b >> SHW) != '0;
                end
                4'd13: begin
                    w_res = {1'b0, WIDTH'(w_dbl >> w_amt)};
                    w_err = (w_b >> SHW) != '0;
                end
                default: ;
            endcase
        end
        w_out = {w_res, w_oflow, w_cout, w_g, w_l, w_e, w_err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_out    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_cmd    <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_have_a <= 1'b0;
        end else if (bus.ce) begin
            case (r_state)
                IDLE: begin
                    r_cmd    <= bus.cmd;
                    r_mode   <= bus.mode;
                    r_cin    <= bus.cin;
                    r_opa    <= bus.opa;
                    r_opb    <= bus.opb;
                    r_have_a <= bus.inp_valid[0];
                    r_cnt    <= '0;
                    if (bus.inp_valid == 2'b00 || w_ill) begin
                        r_out <= ERR_OUT;
                    end else if ((w_need & ~bus.inp_valid) == 2'b00) begin
                        if (w_mul) r_state <= MUL;
                        else       r_out   <= w_out;
                    end else if (w_need == 2'b11) begin
                        r_state <= WAIT;
                    end else begin
                        r_out <= ERR_OUT;
                    end
                end
                WAIT: begin
                    if (r_have_a ? bus.inp_valid[1] : bus.inp_valid[0]) begin
                        r_opa <= w_a;
                        r_opb <= w_b;
                        if (w_mul) begin
                            r_state <= MUL;
                        end else begin
                            r_out   <= w_out;
                            r_state <= IDLE;
                        end
                    end else if (r_cnt == 4'hF) begin
                        r_out   <= ERR_OUT;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                MUL: begin
                    r_out   <= w_out;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign {bus.res, bus.oflow, bus.cout, bus.g, bus.l, bus.e, bus.err} = r_out;
endmodule

// File: tb/tb_alu_core.sv
// Directed scoreboard bench for alu_core (WIDTH=8): expectations are queued as stimulus
// is driven and popped when the result is due.
module tb_alu_core;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    alu_core_if #(.WIDTH(W), .CMD_WIDTH(4)) bus ();
    alu_core #(.WIDTH(W), .CMD_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef logic [W+6:0] out_t;
    typedef struct { string tag; out_t val; } exp_t;
    typedef struct packed {
        logic       m;
        logic [3:0] c;
        logic       ci;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] iv;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    out_t last_exp = '0;

    function automatic out_t pk(logic [W:0] r, logic of, logic co, logic g, logic l, logic e, logic er);
        return {r, of, co, g, l, e, er};
    endfunction

    // Reference model for single-pass (all operands present) operations.
    function automatic out_t ref_alu(logic m, int c, logic ci, int a, int b, logic [1:0] iv);
        int r = 0;
        int s;
        logic of = 0, co = 0, g = 0, l = 0, e = 0, er = 0;
        logic na = 1, nb = 1, bad = 0;
        if (m) begin
            if (c == 4 || c == 5) nb = 0;
            if (c == 6 || c == 7) na = 0;
            if (c > 10) bad = 1;
        end else begin
            if (c == 6 || c == 8 || c == 9) nb = 0;
            if (c == 7 || c == 10 || c == 11) na = 0;
            if (c > 13) bad = 1;
        end
        if (iv == 2'b00 || bad || (na && !iv[0]) || (nb && !iv[1]))
            return pk('0, 0, 0, 0, 0, 0, 1);
        s = b % 8;
        if (m) begin
            case (c)
                0:  begin r = a + b;      co = r > 255; end
                1:  begin r = a - b;      of = a < b; end
                2:  begin r = a + b + ci; co = r > 255; end
                3:  begin r = a - b - ci; of = a < b + ci; end
                4:  begin r = a + 1;      of = a == 255; end
                5:  begin r = a - 1;      of = a == 0; end
                6:  begin r = b + 1;      of = b == 255; end
                7:  begin r = b - 1;      of = b == 0; end
                8:  begin g = a > b; l = a < b; e = a == b; end
                9:  r = (a + 1) * (b + 1);
                10: r = (a * 2) * b;
                default: ;
            endcase
        end else begin
            case (c)
                0:  r = a & b;
                1:  r = ~(a & b);
                2:  r = a | b;
                3:  r = ~(a | b);
                4:  r = a ^ b;
                5:  r = ~(a ^ b);
                6:  r = ~a;
                7:  r = ~b;
                8:  r = a >> 1;
                9:  r = a << 1;
                10: r = b >> 1;
                11: r = b << 1;
                12: begin r = (a << s) | (a >> (8 - s)); er = b >= 8; end
                13: begin r = (a >> s) | (a << (8 - s)); er = b >= 8; end
                default: ;
            endcase
            r = r & 255;
        end
        r = r & 511;
        return pk(r[8:0], of, co, g, l, e, er);
    endfunction

    task automatic drive(logic m, logic [3:0] c, logic [7:0] a, logic [7:0] b,
                         logic [1:0] iv, logic ci = 1'b0, logic ce = 1'b1);
        bus.mode      = m;
        bus.cmd       = c;
        bus.opa       = a;
        bus.opb       = b;
        bus.inp_valid = iv;
        bus.cin       = ci;
        bus.ce        = ce;
    endtask

    task automatic check_pop();
        exp_t x;
        out_t obs;
        obs = {bus.res, bus.oflow, bus.cout, bus.g, bus.l, bus.e, bus.err};
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_empty: observed %h required a queued expectation", obs);
            return;
        end
        x = sb.pop_front();
        assert (obs === x.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.val);
        end
    endtask

    // Queue the expectation, clock one edge, then compare away from the edge.
    task automatic op(string tag, out_t v);
        sb.push_back('{tag, v});
        last_exp = v;
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic hold(string tag);
        op(tag, last_exp);
    endtask

    vec_t vecs [0:18] = '{
        '{1'b1, 4'd1,  1'b0, 8'h03, 8'h05, 2'b11},
        '{1'b1, 4'd3,  1'b1, 8'h05, 8'h04, 2'b11},
        '{1'b1, 4'd3,  1'b1, 8'h04, 8'h04, 2'b11},
        '{1'b1, 4'd2,  1'b1, 8'hFF, 8'hFF, 2'b11},
        '{1'b1, 4'd4,  1'b0, 8'hFF, 8'h00, 2'b01},
        '{1'b1, 4'd7,  1'b0, 8'h00, 8'h00, 2'b10},
        '{1'b1, 4'd5,  1'b0, 8'h00, 8'h00, 2'b10},
        '{1'b1, 4'd6,  1'b0, 8'h00, 8'h7F, 2'b10},
        '{1'b1, 4'd0,  1'b0, 8'h11, 8'h22, 2'b00},
        '{1'b1, 4'd11, 1'b0, 8'h11, 8'h22, 2'b11},
        '{1'b0, 4'd1,  1'b0, 8'hF0, 8'h3C, 2'b11},
        '{1'b0, 4'd5,  1'b0, 8'hF0, 8'h3C, 2'b11},
        '{1'b0, 4'd9,  1'b0, 8'h81, 8'h00, 2'b01},
        '{1'b0, 4'd10, 1'b0, 8'h00, 8'h81, 2'b10},
        '{1'b0, 4'd12, 1'b0, 8'h81, 8'h01, 2'b11},
        '{1'b0, 4'd13, 1'b0, 8'h81, 8'h01, 2'b11},
        '{1'b0, 4'd13, 1'b0, 8'h81, 8'h0B, 2'b11},
        '{1'b0, 4'd14, 1'b0, 8'h12, 8'h34, 2'b11},
        '{1'b0, 4'd12, 1'b0, 8'h5A, 8'h08, 2'b11}
    };

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        op("reset", '0);
        rst = 1'b0;

        drive(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11);
        op("add_ff_01", pk(9'h100, 0, 1, 0, 0, 0, 0));
        drive(1'b1, 4'd8, 8'h05, 8'h05, 2'b11);
        op("cmp_eq", pk(9'h000, 0, 0, 0, 0, 1, 0));
        drive(1'b1, 4'd8, 8'h06, 8'h05, 2'b11);
        op("cmp_gt", pk(9'h000, 0, 0, 1, 0, 0, 0));

        drive(1'b1, 4'd9, 8'h03, 8'h04, 2'b11);
        hold("mul_inc_latch");
        drive(1'b1, 4'd0, 8'h01, 8'h04, 2'b11);
        op("mul_inc_res", pk(9'h014, 0, 0, 0, 0, 0, 0));
        drive(1'b1, 4'd0, 8'h01, 8'h04, 2'b11, 1'b0, 1'b0);
        hold("mul_add_dropped");

        foreach (vecs[i]) begin
            drive(vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].iv, vecs[i].ci);
            op($sformatf("vec%0d_m%0d_c%0d", i, vecs[i].m, vecs[i].c),
               ref_alu(vecs[i].m, int'(vecs[i].c), vecs[i].ci, int'(vecs[i].a),
                       int'(vecs[i].b), vecs[i].iv));
        end

        drive(1'b1, 4'd10, 8'h81, 8'h03, 2'b11);
        hold("mul_shl_latch");
        drive(1'b0, 4'd14, 8'h00, 8'h00, 2'b00);
        op("mul_shl_res", pk(9'h106, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 4'd9, 8'h02, 8'h02, 2'b11);
        hold("mul_ce_latch");
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        hold("mul_ce0_frozen");
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00);
        op("mul_ce_res", pk(9'h009, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 4'd0, 8'h10, 8'h00, 2'b01);
        hold("wait_enter");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd5, 8'hFF, 8'hFF, 2'b00);
            hold($sformatf("wait_hold%0d", i));
        end
        drive(1'b0, 4'd5, 8'hEE, 8'h22, 2'b10);
        op("wait_add", pk(9'h032, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 4'd0, 8'h10, 8'h00, 2'b01);
        hold("tmo_enter");
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00);
            hold($sformatf("tmo_hold%0d", i));
            if (i == 7) begin
                drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
                hold("tmo_ce0");
            end
        end
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00);
        op("tmo_err", pk(9'h000, 0, 0, 0, 0, 0, 1));
        drive(1'b1, 4'd0, 8'h01, 8'h02, 2'b11);
        op("tmo_next_add", pk(9'h003, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 4'd9, 8'h00, 8'h02, 2'b10);
        hold("wmul_enter");
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00);
        hold("wmul_wait");
        drive(1'b1, 4'd0, 8'h02, 8'h00, 2'b01);
        hold("wmul_j");
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00);
        op("wmul_res", pk(9'h009, 0, 0, 0, 0, 0, 0));

        drive(1'b1, 4'd9, 8'h03, 8'h04, 2'b11);
        hold("rmul_latch");
        rst = 1'b1;
        op("rst_mul_1", '0);
        op("rst_mul_2", '0);
        rst = 1'b0;
        drive(1'b1, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
        op("rst_no_late", '0);
        drive(1'b1, 4'd0, 8'h01, 8'h02, 2'b11);
        op("rst_first_add", pk(9'h003, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
- REQ-001: Parameters: WIDTH, default 8, operand width; CMD_WIDTH, default 4, command width.
- REQ-002: One clock; reset is synchronous and active-high.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst  input  1  synchronous active-high reset.
- REQ-005: opa, opb  input  WIDTH  operands A and B.
- REQ-006: ce  input  1  clock enable; 0 freezes all state and outputs.
- REQ-007: mode  input  1  operation class: 1 arithmetic, 0 logical.
- REQ-008: cin  input  1  carry/borrow in, used by ADD_CIN and SUB_CIN.
- REQ-009: inp_valid  input  2  operand valid: bit0 marks opa valid, bit1 marks opb valid.
- REQ-010: cmd  input  CMD_WIDTH  opcode.
- REQ-011: res  output  WIDTH+1  registered result.
- REQ-012: oflow, cout, g, l, e, err  output  1 each  registered flags.

Function
- REQ-013: Arithmetic opcodes (mode=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN (A+B+cin), 3 SUB_CIN (A-B-cin)
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
  - 8 CMP
  - 9 MUL_INC: (A+1)*(B+1)
  - 10 MUL_SHL: (A<<1)*B
- REQ-014: Logical opcodes (mode=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B: rotate A by opb[log2(WIDTH)-1:0]
- REQ-015: Any other opcode: err=1, res=0, all other flags 0.
- REQ-016: Logical results are zero-extended to WIDTH+1 bits.
- REQ-017: Arithmetic results use WIDTH+1 bits; multiply products are truncated to the low WIDTH+1 bits.
- REQ-018: Flag rules:
  - cout = res[WIDTH] for ADD and ADD_CIN, else 0.
  - oflow=1 on borrow for SUB/SUB_CIN (A < B+cin), on INC wrap from all-ones, and on DEC from 0; else 0.
- REQ-019: CMP: res=0; g, l, e set by A>B, A<B, A==B, exactly one high; g, l, e are 0 for every other opcode.
- REQ-020: Rotate with any opb bit at or above log2(WIDTH) set: err=1, rotated result still driven.
- REQ-021: Single-operand opcodes (INC_A, DEC_A, NOT_A, SHx_A need bit0; INC_B, DEC_B, NOT_B, SHx_B need bit1) with the required bit clear: err=1, res=0.
- REQ-022: inp_valid=00 with ce=1: err=1, res=0, no state change.
- REQ-023: State machine states are IDLE, WAIT and MUL; all transitions occur only on edges with ce=1.
- REQ-024: IDLE, all needed operands valid, non-multiply opcode: outputs updated at the same edge k (1-cycle latency, sampled by the monitor at k+1).
- REQ-025: IDLE, multiply opcode with inp_valid=11: operands latched at edge k, go to MUL, result written at edge k+1, return to IDLE.
- REQ-026: In MUL, inputs presented at edge k+1 are ignored.
- REQ-027: IDLE, two-operand opcode with inp_valid=01 or 10: latch cmd, mode, cin and the valid operand; clear a 4-bit timeout counter; go to WAIT; outputs hold.
- REQ-028: WAIT: cmd and mode inputs are ignored; the counter increments on each ce=1 edge.
- REQ-029: WAIT, missing-operand bit seen at edge j (inp_valid=11 or the complementary bit): compute with latched + new operand.
- REQ-030: WAIT completion: non-multiply results are written at j; multiply goes to MUL with its result at j+1; then return to IDLE.
- REQ-031: WAIT with 16 edges and no missing operand: err=1, res=0 at the 16th edge; return to IDLE.
- REQ-032: ce=0 in any state: outputs, state and counter hold; a pending multiply does not advance.

Reset
- REQ-033: rst=1 at an edge sets res=0, all flags=0, state=IDLE and counter=0, regardless of ce.
- REQ-034: Reset mid-WAIT or mid-MUL discards the pending operation; no late result appears.
- REQ-035: The first edge with rst=0 accepts a new operation normally.

Verification (WIDTH=8)
- REQ-036: rst=1 for 2 edges during a pending multiply -> all outputs 0 and remain 0 the next cycle with inp_valid=00, ce=0.
- REQ-037: mode=1, cmd=0, opa=FF, opb=01, inp_valid=11 -> res=9'h100, cout=1, err=0 after the same edge.
- REQ-038: mode=1, cmd=8, opa=05, opb=05 -> res=0, e=1, g=0, l=0; then opa=06 -> g=1, e=0.
- REQ-039: mode=1, cmd=9, opa=03, opb=04 at edge k, then cmd=0 with opa=01 at k+1 -> res=9'h014 at k+1, and the ADD at k+1 is dropped.
- REQ-040: mode=1, cmd=0, inp_valid=01, opa=10, then inp_valid=10, opb=22 five edges later -> res=9'h032 at that edge.
- REQ-041: Repeat REQ-040 with no second operand -> err=1, res=0 at the 16th edge.
- REQ-042: mode=0, cmd=14 -> err=1, res=0.
- REQ-043: mode=0, cmd=12, opb=08 -> err=1.
